crossing_interval_timer: RTL and testbench
==========================================

Name: crossing_interval_timer

Overview:
- Responder side of the controller timer interface (sel/ld in, T out).
- Each pedestrian-crossing controller FSM drives it: a one-hot sel with a coincident one-cycle ld starts the selected interval.
- When the interval elapses, the block returns a one-cycle one-hot T pulse on the matching bit.
- Also provides busy, a remaining-tick count for the countdown display, and an error pulse for malformed loads.

Parameters:
- TICK_DIV, 4, clk cycles per timer tick (>=1; 1 means a tick every cycle).
- DUR0, 1, interval 0 length in ticks (1..255; 0 is treated as 1).
- DUR1, 2, interval 1 length in ticks (1..255; 0 is treated as 1).
- DUR2, 3, interval 2 length in ticks, the waiting time (1..255; 0 is treated as 1).
- DUR3, 5, interval 3 length in ticks, the crossing time (1..255; 0 is treated as 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ld  input  1  one-cycle load strobe, sampled with sel.
- sel  input  4  one-hot interval select, valid when ld=1.
- T  output  4  one-hot expiry pulse; bit k high for one cycle when interval k ends.
- busy  output  1  high while an interval is running.
- remaining  output  8  ticks left in the current interval; 0 when idle.
- tick  output  1  one-cycle prescaler pulse, present only while busy.
- err  output  1  one-cycle pulse on a malformed load.

Behaviour:
- Reset (async): T=0, busy=0, remaining=0, tick=0, err=0, prescaler=0, state IDLE, active index cleared. Reset mid-interval aborts it with no T pulse.
- States:
  - IDLE: waiting for a load.
  - RUN: counting down.
  - Expiry: transient; T pulses, then back to IDLE.
- Load sampling: at rising edge E0 with ld=1:
  - sel exactly one-hot (bit k): active index=k, remaining=DURk, prescaler=0, busy=1, state RUN. Accepted from IDLE or RUN. In RUN the current interval is aborted and restarted with the new sel, and no T is emitted for the aborted interval.
  - sel=0: cancel. State IDLE, busy=0, remaining=0, no T, no err.
  - sel with more than one bit set: err=1 for one cycle, load ignored, current state/interval unchanged.
- Prescaler (RUN only):
  - Counts 0..TICK_DIV-1.
  - When it equals TICK_DIV-1: tick=1 for the next cycle, prescaler wraps to 0, remaining decrements.
  - Held at 0 in IDLE.
- Expiry:
  - On the edge where remaining goes 1->0: T[active]=1, busy=0, state IDLE.
  - T returns to 0 at the next edge.
  - Expiry edge is E0 + DURk*TICK_DIV clocks; T is high in the cycle after that edge.
- Simultaneous ld and expiry edge: ld wins. The new interval starts and the old T is suppressed.
- T is never multi-hot, and never asserted while busy=1 after the same edge.
- remaining width is 8 bits. DUR values above 255 are a parameter error; a synthesis-time check is required.
- Latency: load to busy=1 is 1 edge; load to remaining=DURk is 1 edge.
- ld=0: sel is don't-care.

Test Plan:
- Reset, then ld=1 with sel=4'b0100 (defaults) -> busy=1, remaining=3. It decrements every 4 clks, T=4'b0100 pulses exactly one cycle 12 clks after the load edge, then busy=0 and remaining=0.
- Load sel=4'b1000, then reload sel=4'b0001 at 7 clks -> no T[3] pulse. T=4'b0001 pulses 4 clks after the second load.
- Load sel=4'b0110 while IDLE, and again while running sel=4'b0100 -> err pulses one cycle each time. In the running case the interval continues and T[2] still arrives on schedule.
- Load sel=4'b1000, then ld with sel=0 after 5 clks -> busy=0 and remaining=0 next edge; no T for 30 clks.
- Load sel=4'b0001, then issue ld sel=4'b0010 on the exact expiry edge (4 clks) -> T stays 0, remaining=2, T[1] pulses 8 clks later.
- Assert reset asynchronously mid-interval -> all outputs 0 immediately. After release, no T pulse appears without a new ld.

Source files
------------

// File: rtl/crossing_interval_timer.sv
// Interval timer used by the pedestrian-crossing controller.
// Ports: clk, reset (async, active-high), ld/sel load, T expiry, busy, remaining, tick, err.
module crossing_interval_timer #(
  parameter int TICK_DIV = 4,
  parameter int DUR0     = 1,
  parameter int DUR1     = 2,
  parameter int DUR2     = 3,
  parameter int DUR3     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld,
  input  logic [3:0] sel,
  output logic [3:0] T,
  output logic       busy,
  output logic [7:0] remaining,
  output logic       tick,
  output logic       err
);

  if (DUR0 > 255 || DUR1 > 255 || DUR2 > 255 || DUR3 > 255 ||
      TICK_DIV < 1) begin : g_param_err
    $error("crossing_interval_timer: bad DURx or TICK_DIV");
  end

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);

  // Zero durations behave as a single tick.
  localparam logic [7:0] D0 = (DUR0 == 0) ? 8'd1 : 8'(DUR0);
  localparam logic [7:0] D1 = (DUR1 == 0) ? 8'd1 : 8'(DUR1);
  localparam logic [7:0] D2 = (DUR2 == 0) ? 8'd1 : 8'(DUR2);
  localparam logic [7:0] D3 = (DUR3 == 0) ? 8'd1 : 8'(DUR3);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    rem_q, rem_d;
  logic [1:0]    act_q, act_d;
  logic [3:0]    t_q, t_d;
  logic          tick_q, tick_d;
  logic          err_q, err_d;

  logic       sel_one;
  logic       ld_one, ld_zero, ld_bad;
  logic       run, wrap, expire;
  logic [1:0] idx;
  logic [7:0] dur;

  assign sel_one = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign ld_one  = ld && sel_one;
  assign ld_zero = ld && (sel == 4'd0);
  assign ld_bad  = ld && !sel_one && (sel != 4'd0);
  assign run     = (state_q == RUN);
  assign wrap    = run && (presc_q == TOP);
  // A valid load or cancel on the final tick edge wins over expiry.
  assign expire  = wrap && (rem_q == 8'd1) && !ld_one && !ld_zero;

  always_comb begin
    idx = 2'd0;
    case (1'b1)
      sel[0]:  idx = 2'd0;
      sel[1]:  idx = 2'd1;
      sel[2]:  idx = 2'd2;
      sel[3]:  idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  always_comb begin
    dur = D0;
    case (idx)
      2'd0:    dur = D0;
      2'd1:    dur = D1;
      2'd2:    dur = D2;
      default: dur = D3;
    endcase
  end

  // State register and datapath flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      rem_q   <= '0;
      act_q   <= '0;
      t_q     <= '0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      act_q   <= act_d;
      t_q     <= t_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (ld_one)       state_d = RUN;
    else if (ld_zero) state_d = IDLE;
    else if (expire)  state_d = IDLE;
  end

  // Datapath next values.
  always_comb begin
    presc_d = presc_q;
    rem_d   = rem_q;
    act_d   = act_q;
    t_d     = 4'd0;
    tick_d  = 1'b0;
    err_d   = ld_bad;
    if (ld_one) begin
      act_d   = idx;
      rem_d   = dur;
      presc_d = '0;
    end else if (ld_zero) begin
      rem_d   = '0;
      presc_d = '0;
    end else if (run) begin
      if (wrap) begin
        presc_d = '0;
        rem_d   = rem_q - 8'd1;
        // No tick on the expiry edge: busy drops there.
        tick_d  = !expire;
        if (expire) t_d = 4'd1 << act_q;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Outputs.
  always_comb begin
    T         = t_q;
    busy      = run;
    remaining = rem_q;
    tick      = tick_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_crossing_interval_timer.sv
// Self-checking bench for crossing_interval_timer.
// Scoreboard of expected T pulses plus direct output checks.
module tb_crossing_interval_timer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld;
  logic [3:0] sel;
  logic [3:0] T;
  logic       busy;
  logic [7:0] remaining;
  logic       tick;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  int dur[4] = '{1, 2, 3, 5};

  typedef struct {
    int unsigned cyc;
    logic [3:0]  t;
  } exp_t;
  exp_t q[$];

  crossing_interval_timer #(
    .TICK_DIV(DIV), .DUR0(1), .DUR1(2), .DUR2(3), .DUR3(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ld(ld),
    .sel(sel),
    .T(T),
    .busy(busy),
    .remaining(remaining),
    .tick(tick),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every T pulse must match the queue head.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0 && q[0].cyc < cyc) begin
      check("T_missed", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (T != 4'd0) begin
      check("T_onehot", 32'($onehot(T)), 1);
      check("T_busy", busy, 0);
      if (q.size() == 0) begin
        check("T_unexp", T, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("T_val", T, e.t);
        check("T_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [3:0] s);
    int k;
    k = 0;
    if ($onehot(s)) begin
      q.delete();
      for (int i = 0; i < 4; i++) if (s[i]) k = i;
      q.push_back('{cyc + 1 + dur[k] * DIV, s});
    end else if (s == 4'd0) begin
      q.delete();
    end
    ld  = 1'b1;
    sel = s;
    step(1);
    ld  = 1'b0;
    sel = 4'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    ld    = 1'b0;
    sel   = 4'd0;
    #3;
    check("rst_T", T, 0);
    check("rst_busy", busy, 0);
    check("rst_rem", remaining, 0);
    check("rst_tick", tick, 0);
    check("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    step(1);

    // Basic interval 2.
    load(4'b0100);
    check("t1_busy", busy, 1);
    check("t1_rem3", remaining, 3);
    check("t1_tick0", tick, 0);
    step(4);
    check("t1_rem2", remaining, 2);
    check("t1_tick", tick, 1);
    step(1);
    check("t1_tick_lo", tick, 0);
    step(3);
    check("t1_rem1", remaining, 1);
    step(4);
    check("t1_T", T, 4'b0100);
    check("t1_idle", busy, 0);
    check("t1_rem0", remaining, 0);
    check("t1_notick", tick, 0);
    step(1);
    check("t1_T_lo", T, 0);
    step(3);

    // Reload aborts interval 3.
    load(4'b1000);
    step(6);
    load(4'b0001);
    check("t2_rem", remaining, 1);
    check("t2_busy", busy, 1);
    step(3);
    step(1);
    check("t2_T", T, 4'b0001);
    step(3);

    // Malformed loads.
    load(4'b0110);
    check("t3_err_idle", err, 1);
    check("t3_busy_idle", busy, 0);
    step(1);
    check("t3_err_lo", err, 0);
    load(4'b0100);
    step(3);
    load(4'b0110);
    check("t3_err_run", err, 1);
    check("t3_busy_run", busy, 1);
    check("t3_rem_run", remaining, 2);
    step(1);
    check("t3_err_lo2", err, 0);
    step(9);
    check("t3_done", busy, 0);
    step(2);

    // Cancel.
    load(4'b1000);
    step(4);
    load(4'b0000);
    check("t4_busy", busy, 0);
    check("t4_rem", remaining, 0);
    check("t4_err", err, 0);
    step(30);

    // Load on the expiry edge.
    load(4'b0001);
    step(3);
    load(4'b0010);
    check("t5_T", T, 0);
    check("t5_rem", remaining, 2);
    check("t5_busy", busy, 1);
    step(10);
    check("t5_idle", busy, 0);

    // Async reset mid-interval.
    load(4'b1000);
    step(5);
    #1 reset = 1'b1;
    q.delete();
    #1;
    check("t6_T", T, 0);
    check("t6_busy", busy, 0);
    check("t6_rem", remaining, 0);
    check("t6_tick", tick, 0);
    check("t6_err", err, 0);
    #2 reset = 1'b0;
    step(30);
    check("t6_idle", busy, 0);

    step(2);
    check("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
